// File: rtl/interrupt_pending_unit.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_pending_unit (with helper priority_encoder)
//  Description : Captures raw interrupt lines into a pending register, gates
//                them with a software mask and presents the highest-index
//                enabled request to the core over a req/ack handshake.
//  Build macro : INTERRUPT_EDGE_DETECT_EN
//                  defined   -> edge mode (rising edges latched, ack clears)
//                  undefined -> level mode (pending is a registered copy)
//  Ports       : clk        - clock, all state changes on rising edge
//                reset      - synchronous active-high reset
//                irq_lines  - raw interrupt sources [LINES]
//                mask_we    - mask register write strobe
//                mask_in    - new mask value (1 = line enabled) [LINES]
//                mask       - current mask register [LINES]
//                pending    - current pending register [LINES]
//                int_req    - interrupt presented to the core
//                int_index  - index of presented interrupt [OUT_WIDTH]
//                int_ack    - core accepts the presented interrupt
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  priority_encoder: highest set index wins; on flags any set bit.
// ----------------------------------------------------------------------------
module priority_encoder #(
    parameter int OUT_WIDTH = 3,
    parameter int LINES     = 1 << OUT_WIDTH
) (
    input  logic [LINES-1:0]     lines,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 on
);

    // Ascending scan: later (higher) indices overwrite earlier ones.
    always_comb begin
        out = '0;
        on  = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            if (lines[i]) begin
                out = OUT_WIDTH'(i);
                on  = 1'b1;
            end
        end
    end

endmodule

module interrupt_pending_unit #(
    parameter int OUT_WIDTH = 3,
    parameter int LINES     = 1 << OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LINES-1:0]     irq_lines,
    input  logic                 mask_we,
    input  logic [LINES-1:0]     mask_in,
    output logic [LINES-1:0]     mask,
    output logic [LINES-1:0]     pending,
    output logic                 int_req,
    output logic [OUT_WIDTH-1:0] int_index,
    input  logic                 int_ack
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_load_index;
    logic [LINES-1:0]       r_mask;
    logic [LINES-1:0]       r_pending;
    logic [OUT_WIDTH-1:0]   r_int_index;
    logic [LINES-1:0]       w_enabled;
    logic [OUT_WIDTH-1:0]   w_enc_out;
    logic                   w_enc_on;

    assign w_enabled = r_pending & r_mask;

    priority_encoder #(
        .OUT_WIDTH (OUT_WIDTH),
        .LINES     (LINES)
    ) u_priority_encoder (
        .lines (w_enabled),
        .out   (w_enc_out),
        .on    (w_enc_on)
    );

    // ------------------------------------------------------------------
    // Pending capture
    // ------------------------------------------------------------------
`ifdef INTERRUPT_EDGE_DETECT_EN
    logic [LINES-1:0] r_irq_prev;
    logic [LINES-1:0] w_rise;
    logic [LINES-1:0] w_ack_clear;

    assign w_rise      = irq_lines & ~r_irq_prev;
    assign w_ack_clear = ((r_state == PRESENT) && int_ack)
                         ? (LINES'(1) << r_int_index) : '0;

    // History loads the live lines on reset so a line already high at
    // reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_prev <= irq_lines;
            r_pending  <= '0;
        end else begin
            r_irq_prev <= irq_lines;
            // Set is OR-ed after the clear so a same-cycle rise wins.
            r_pending  <= (r_pending & ~w_ack_clear) | w_rise;
        end
    end
`else
    // Level mode: pending simply mirrors the lines one cycle late; the
    // ack has no effect on it, a held line is re-presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= irq_lines;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Mask register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (mask_we) begin
            r_mask <= mask_in;
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The index is only sampled on the IDLE->PRESENT transition, so it is
    // frozen for the whole presentation regardless of new requests or mask
    // changes.
    always_comb begin
        w_state_next = r_state;
        w_load_index = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_enc_on) begin
                    w_state_next = PRESENT;
                    w_load_index = 1'b1;
                end
            end
            PRESENT: begin
                if (int_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_int_index <= '0;
        end else if (w_load_index) begin
            r_int_index <= w_enc_out;
        end
    end

    assign int_req   = (r_state == PRESENT);
    assign int_index = r_int_index;
    assign mask      = r_mask;
    assign pending   = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_pending_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_pending_unit
//  Description : Self-checking bench for interrupt_pending_unit. Directed
//                scenarios followed by random traffic, each cycle compared
//                with a behavioural model of the pending/mask/present rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_pending_unit;

    localparam int OUT_WIDTH = 3;
    localparam int LINES     = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [LINES-1:0]     irq_lines;
    logic                 mask_we;
    logic [LINES-1:0]     mask_in;
    logic [LINES-1:0]     mask;
    logic [LINES-1:0]     pending;
    logic                 int_req;
    logic [OUT_WIDTH-1:0] int_index;
    logic                 int_ack;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0] m_pend = '0;
    logic [7:0] m_mask = '0;
    logic [7:0] m_prev = '0;
    logic       m_pres = 1'b0;
    int         m_idx  = 0;

    always #5 clk = ~clk;

    interrupt_pending_unit #(
        .OUT_WIDTH (OUT_WIDTH),
        .LINES     (LINES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_lines (irq_lines),
        .mask_we   (mask_we),
        .mask_in   (mask_in),
        .mask      (mask),
        .pending   (pending),
        .int_req   (int_req),
        .int_index (int_index),
        .int_ack   (int_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int top_index(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock: drive inputs at negedge, advance model at posedge, compare.
    task automatic step(input logic rst, input logic [7:0] irq, input logic we,
                        input logic [7:0] mi, input logic ack);
        logic [7:0] enabled;
        logic [7:0] nxt;
        @(negedge clk);
        reset     = rst;
        irq_lines = irq;
        mask_we   = we;
        mask_in   = mi;
        int_ack   = ack;
        @(posedge clk);
        enabled = m_pend & m_mask;
        if (rst) begin
            m_pend = '0;
            m_mask = '0;
            m_pres = 1'b0;
            m_idx  = 0;
        end else begin
`ifdef INTERRUPT_EDGE_DETECT_EN
            nxt = m_pend;
            if (m_pres && ack) nxt[m_idx] = 1'b0;
            nxt = nxt | (irq & ~m_prev);
`else
            nxt = irq;
`endif
            if (!m_pres) begin
                if (enabled != 0) begin
                    m_pres = 1'b1;
                    m_idx  = top_index(enabled);
                end
            end else if (ack) begin
                m_pres = 1'b0;
            end
            if (we) m_mask = mi;
            m_pend = nxt;
        end
        m_prev = irq;
        #1;
        chk("int_req", 32'(int_req), 32'(m_pres));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("mask",    32'(mask),    32'(m_mask));
        if (m_pres || rst) chk("int_index", 32'(int_index), 32'(m_idx));
    endtask

    // Hold lines and acknowledge every presentation after it has been seen.
    task automatic serve(input logic [7:0] irq, input int n);
        for (int i = 0; i < n; i++) step(1'b0, irq, 1'b0, 8'h00, m_pres);
    endtask

    task automatic hold(input logic [7:0] irq, input int n);
        for (int i = 0; i < n; i++) step(1'b0, irq, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] rnd_irq;
        reset = 1'b1; irq_lines = '0; mask_we = 1'b0; mask_in = '0; int_ack = 1'b0;

        // Reset with line 2 already high
        step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
        chk("rst_int_req",   32'(int_req),   32'd0);
        chk("rst_int_index", 32'(int_index), 32'd0);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_mask",      32'(mask),      32'd0);

        // Open the mask, line 2 still high from before reset
        step(1'b0, 8'h04, 1'b1, 8'hFF, 1'b0);
        hold(8'h04, 4);
`ifdef INTERRUPT_EDGE_DETECT_EN
        chk("no_fire_held_line", 32'(int_req), 32'd0);
`else
        chk("level_present_2", 32'(int_index), 32'd2);
`endif
        serve(8'h00, 4);
        // Line 2 rises again: request two edges later
        step(1'b0, 8'h04, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h04, 1'b0, 8'h00, 1'b0);
        chk("rise2_req",   32'(int_req),   32'd1);
        chk("rise2_index", 32'(int_index), 32'd2);
        serve(8'h00, 4);

        // Lines 1, 5, 6 together -> served 6, 5, 1
        hold(8'h62, 1);
        serve(8'h00, 12);
        chk("multi_drained", 32'(pending), 32'd0);

        // Index 3 presented, line 7 arrives: no preemption
        hold(8'h08, 3);
        hold(8'h88, 3);
        chk("no_preempt", 32'(int_index), 32'd3);
        serve(8'h00, 8);

        // Mask selects line 0 only, then switch to line 4
        step(1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
        hold(8'h11, 1);
        serve(8'h11, 5);
        step(1'b0, 8'h11, 1'b1, 8'h10, 1'b0);
        serve(8'h00, 6);
        step(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
        serve(8'h00, 4);

        // Ack of line 2 while line 2 rises again
        hold(8'h04, 3);
        hold(8'h00, 1);
        step(1'b0, 8'h04, 1'b0, 8'h00, 1'b1);
        hold(8'h04, 2);
        serve(8'h00, 6);

        // Mask write coinciding with ack
        hold(8'h20, 3);
        step(1'b0, 8'h00, 1'b1, 8'h0F, 1'b1);
        serve(8'h00, 4);

        // Reset in the middle of a presentation
        step(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
        hold(8'h40, 3);
        step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h40, 1'b1, 8'hFF, 1'b0);
        hold(8'h40, 2);

        // Random traffic
        rnd_irq = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) rnd_irq = 8'($urandom) & 8'($urandom);
            step(($urandom_range(0, 199) == 0),
                 rnd_irq,
                 ($urandom_range(0, 15) == 0),
                 8'($urandom) | 8'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
